output_buf_ctrl: RTL and testbench

OUTPUT_BUF_CTRL -- requirements
Module: output_buf_ctrl

---
 rtl/output_buf_ctrl.sv | 85 ++++++++
 tb/tb_output_buf_ctrl.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/output_buf_ctrl.sv
// Output-buffer controller. It runs a 16-entry circular FIFO over the systolic result buffer
// and drains the stored words to an external port through a three-state FSM.
module output_buf_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic       res_valid,
  input  logic       drain_start,
  input  logic       ext_ready,
  output logic       op_buffer_instr_for_storing_data,
  output logic [3:0] op_buf_addr_for_store,
  output logic       op_buffer_instr_for_sending_data,
  output logic [3:0] op_buf_addr_for_external_comm,
  output logic       ext_valid,
  output logic [4:0] fill_count,
  output logic       full,
  output logic       empty,
  output logic       busy,
  output logic       drain_done,
  output logic       overflow_err
);

  typedef enum logic [1:0] {IDLE, SEND, LAST} state_t;

  state_t     state_q;
  logic [3:0] wr_ptr_q, rd_ptr_q;
  logic [4:0] count_q, count_d;
  logic       ext_valid_q, drain_done_q, ovf_q;
  logic       store_en, send_en;

  assign full  = (count_q == 5'd16);
  assign empty = (count_q == 5'd0);

  // Strobes are held low during reset so nothing reaches the buffer in that cycle.
  assign store_en = res_valid & ~full & ~rst;
  assign send_en  = (state_q == SEND) & ext_ready & ~empty & ~rst;

  always_comb begin
    count_d = count_q;
    case ({store_en, send_en})
      2'b10:   count_d = count_q + 5'd1;
      2'b01:   count_d = count_q - 5'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      wr_ptr_q     <= 4'd0;
      rd_ptr_q     <= 4'd0;
      count_q      <= 5'd0;
      ext_valid_q  <= 1'b0;
      drain_done_q <= 1'b0;
      ovf_q        <= 1'b0;
    end else begin
      if (store_en) wr_ptr_q <= wr_ptr_q + 4'd1;
      if (send_en)  rd_ptr_q <= rd_ptr_q + 4'd1;
      count_q      <= count_d;
      ext_valid_q  <= send_en;
      drain_done_q <= 1'b0;
      if (res_valid && full) ovf_q <= 1'b1;
      case (state_q)
        IDLE: if (drain_start && !empty) state_q <= SEND;
        // Leave only when this send empties the buffer; a concurrent store keeps us draining.
        SEND: if (send_en && count_d == 5'd0) begin
          state_q      <= LAST;
          drain_done_q <= 1'b1;
        end
        LAST: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign op_buffer_instr_for_storing_data = store_en;
  assign op_buf_addr_for_store            = wr_ptr_q;
  assign op_buffer_instr_for_sending_data = send_en;
  assign op_buf_addr_for_external_comm    = rd_ptr_q;
  assign ext_valid    = ext_valid_q;
  assign fill_count   = count_q;
  assign busy         = (state_q != IDLE);
  assign drain_done   = drain_done_q;
  assign overflow_err = ovf_q;

endmodule

// File: tb/tb_output_buf_ctrl.sv
// Bench for output_buf_ctrl. A queue-based FIFO/drain model is compared against the DUT
// on every cycle, through directed scenarios and then a randomized phase.
module tb_output_buf_ctrl;

  logic       clk = 1'b0;
  logic       rst, res_valid, drain_start, ext_ready;
  logic       st_stb, sd_stb, ext_valid, full, empty, busy, drain_done, overflow_err;
  logic [3:0] st_addr, sd_addr;
  logic [4:0] fill_count;

  int total = 0;
  int passed = 0;

  // Reference model: q holds the addresses of the stored words, oldest first.
  int q[$];
  int mwr = 0, mrd = 0;
  bit mdrain = 0, mlast = 0, mev = 0, movf = 0;

  output_buf_ctrl dut (
    .clk(clk), .rst(rst), .res_valid(res_valid), .drain_start(drain_start),
    .ext_ready(ext_ready),
    .op_buffer_instr_for_storing_data(st_stb), .op_buf_addr_for_store(st_addr),
    .op_buffer_instr_for_sending_data(sd_stb), .op_buf_addr_for_external_comm(sd_addr),
    .ext_valid(ext_valid), .fill_count(fill_count), .full(full), .empty(empty),
    .busy(busy), .drain_done(drain_done), .overflow_err(overflow_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0d, expected %0d", tag, obs, exp);
  endtask

  // Drive one cycle: inputs are applied after the falling edge and checked just before the
  // rising edge. The model is then advanced to match that edge.
  task automatic step(input bit rv, input bit ds, input bit er, input bit r);
    int  n;
    bit  e_st, e_sd;
    res_valid = rv; drain_start = ds; ext_ready = er; rst = r;
    #1;
    n    = q.size();
    e_st = !r && rv && (n < 16);
    e_sd = !r && mdrain && er && (n > 0);
    chk("store_stb", st_stb, e_st);
    chk("send_stb", sd_stb, e_sd);
    if (!r) begin
      chk("store_addr", st_addr, mwr);
      chk("send_addr", sd_addr, (n > 0) ? q[0] : mrd);
      chk("fill_count", fill_count, n);
      chk("full", full, n == 16);
      chk("empty", empty, n == 0);
      chk("busy", busy, mdrain || mlast);
      chk("drain_done", drain_done, mlast);
      chk("ext_valid", ext_valid, mev);
      chk("overflow_err", overflow_err, movf);
    end
    @(posedge clk);
    if (r) begin
      q.delete(); mwr = 0; mrd = 0; mdrain = 0; mlast = 0; mev = 0; movf = 0;
    end else begin
      bit start;
      start = !mdrain && !mlast && ds && (n > 0);
      if (rv && n == 16) movf = 1;
      if (e_sd) begin void'(q.pop_front()); mrd = (mrd + 1) % 16; end
      if (e_st) begin q.push_back(mwr); mwr = (mwr + 1) % 16; end
      mev   = e_sd;
      mlast = e_sd && (q.size() == 0);
      if (mlast) mdrain = 0;
      else if (start) mdrain = 1;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
  endtask

  initial begin
    res_valid = 0; drain_start = 0; ext_ready = 0; rst = 1;
    @(negedge clk);
    do_reset();
    step(0, 0, 0, 0);

    // Three words, then a full-speed drain.
    repeat (3) step(1, 0, 0, 0);
    step(0, 1, 1, 0);
    repeat (5) step(0, 0, 1, 0);
    chk("drain3_fill", fill_count, 0);

    // Overflow: the 17th word is dropped and the error flag sticks.
    do_reset();
    repeat (17) step(1, 0, 0, 0);
    repeat (3) step(0, 0, 0, 0);
    chk("ovf_sticky", overflow_err, 1);
    chk("ovf_full", full, 1);

    // Fill 16, drain 10, store 5 with wrap, then finish the drain.
    do_reset();
    repeat (16) step(1, 0, 0, 0);
    step(0, 1, 0, 0);
    repeat (10) step(0, 0, 1, 0);
    repeat (5) step(1, 0, 0, 0);
    chk("wrap_fill", fill_count, 11);
    chk("wrap_rd", sd_addr, 10);
    repeat (14) step(0, 0, 1, 0);

    // Drain with ext_ready toggling while results keep arriving.
    do_reset();
    repeat (4) step(1, 0, 0, 0);
    step(1, 1, 0, 0);
    for (int i = 0; i < 20; i++) step(1, 0, i[0], 0);
    repeat (40) step(0, 0, 1, 0);

    // Reset in the middle of a drain with five words left.
    do_reset();
    repeat (8) step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    step(0, 1, 0, 0);
    repeat (4) step(0, 0, 1, 0);
    chk("mid_count", fill_count, 5);
    step(0, 0, 1, 1);
    repeat (2) step(0, 0, 1, 0);
    chk("mid_busy", busy, 0);

    // drain_start on an empty buffer is ignored.
    do_reset();
    step(0, 1, 1, 0);
    repeat (3) step(0, 0, 1, 0);

    // Random traffic.
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 1), $urandom_range(0, 9) == 0, $urandom_range(0, 9) < 6,
           $urandom_range(0, 199) == 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
